// File: rtl/amoa_operand_feeder.sv
// Operand feeder for the amoa_8x8 adder family: serial words -> 8-wide vectors -> small FIFO -> x0..x7.
// Define AMOA_FEED_EXACT_EN to build the exact-sum sideband; otherwise exact_sum is tied to zero.
module amoa_operand_feeder #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   x0,
    output logic [W-1:0]   x1,
    output logic [W-1:0]   x2,
    output logic [W-1:0]   x3,
    output logic [W-1:0]   x4,
    output logic [W-1:0]   x5,
    output logic [W-1:0]   x6,
    output logic [W-1:0]   x7,
    output logic           vec_valid,
    input  logic           stall,
    output logic [W+2:0]   exact_sum,
    output logic [15:0]    vec_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [2:0]       idx_q, idx_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [15:0]      vec_cnt_q, vec_cnt_d;
    logic [W-1:0]     asm_q [7];
    logic [W-1:0]     asm_d [7];
    logic [8*W-1:0]   mem_q [DEPTH];
    logic [8*W-1:0]   mem_d [DEPTH];

    logic             full_s, empty_s, pop_s, accept_s, push_s, in_ready_s;
    logic [8*W-1:0]   wr_vec_s;
    logic [8*W-1:0]   head_s;

    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign pop_s   = !empty_s && !stall && !flush;
    // Only the completing word waits for room; stall reaches in_ready through pop_s.
    assign in_ready_s = !flush && ((idx_q != 3'd7) || !full_s || pop_s);
    assign accept_s   = in_valid && in_ready_s;
    assign push_s     = accept_s && (idx_q == 3'd7);

    // Assemble the vector being pushed: slots 0..6 from the buffer, slot 7 straight from the input.
    always_comb begin
        wr_vec_s = '0;
        for (int i = 0; i < 7; i++) begin
            wr_vec_s[i*W +: W] = asm_q[i];
        end
        wr_vec_s[7*W +: W] = in_data;
    end

    // Next-state for assembly index, buffer, FIFO storage, pointers and pop counter.
    always_comb begin
        idx_d     = idx_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        vec_cnt_d = vec_cnt_q;
        mem_d     = mem_q;
        for (int i = 0; i < 7; i++) begin
            asm_d[i] = (accept_s && (idx_q == 3'(i))) ? in_data : asm_q[i];
        end
        if (flush) begin
            // Emptying by pulling the write pointer back keeps the head outputs bit-stable.
            idx_d    = 3'd0;
            wr_ptr_d = rd_ptr_q;
        end else begin
            if (accept_s) begin
                idx_d = idx_q + 3'd1;
            end else begin
                idx_d = idx_q;
            end
            if (push_s) begin
                mem_d[wr_ptr_q[AW-1:0]] = wr_vec_s;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d  = rd_ptr_q + PTR_ONE;
                vec_cnt_d = vec_cnt_q + 16'd1;
            end else begin
                rd_ptr_d  = rd_ptr_q;
                vec_cnt_d = vec_cnt_q;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= 3'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            vec_cnt_q <= 16'd0;
            for (int i = 0; i < 7; i++) begin
                asm_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            idx_q     <= idx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            vec_cnt_q <= vec_cnt_d;
            asm_q     <= asm_d;
            mem_q     <= mem_d;
        end
    end

    assign head_s    = mem_q[rd_ptr_q[AW-1:0]];
    assign x0        = head_s[0*W +: W];
    assign x1        = head_s[1*W +: W];
    assign x2        = head_s[2*W +: W];
    assign x3        = head_s[3*W +: W];
    assign x4        = head_s[4*W +: W];
    assign x5        = head_s[5*W +: W];
    assign x6        = head_s[6*W +: W];
    assign x7        = head_s[7*W +: W];
    assign vec_valid = !empty_s;
    assign in_ready  = in_ready_s;
    assign vec_cnt   = vec_cnt_q;

`ifdef AMOA_FEED_EXACT_EN
    logic [W+2:0] acc_q, acc_d;
    logic [W+2:0] acc_next_s;
    logic [W+2:0] sum_q [DEPTH];
    logic [W+2:0] sum_d [DEPTH];

    // Running sum restarts at word 0, so a flushed partial vector never leaks in.
    assign acc_next_s = ((idx_q == 3'd0) ? {(W+3){1'b0}} : acc_q) + {3'b000, in_data};

    // Accumulator and per-entry sum storage follow the word/vector handshakes.
    always_comb begin
        acc_d = acc_q;
        sum_d = sum_q;
        if (accept_s) begin
            acc_d = acc_next_s;
        end else begin
            acc_d = acc_q;
        end
        if (push_s) begin
            sum_d[wr_ptr_q[AW-1:0]] = acc_next_s;
        end else begin
            sum_d = sum_q;
        end
    end

    // Exact-sum registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sum_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    assign exact_sum = sum_q[rd_ptr_q[AW-1:0]];
`else
    assign exact_sum = {(W+3){1'b0}};
`endif

endmodule

// File: tb/tb_amoa_operand_feeder.sv
// Directed self-checking bench for amoa_operand_feeder; expected exact_sum follows AMOA_FEED_EXACT_EN.
module tb_amoa_operand_feeder;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, stall;
    logic [7:0]  in_data;
    logic        in_ready, vec_valid;
    logic [7:0]  x0, x1, x2, x3, x4, x5, x6, x7;
    logic [10:0] exact_sum;
    logic [15:0] vec_cnt;

    int total = 0;
    int bad   = 0;

`ifdef AMOA_FEED_EXACT_EN
    localparam bit EXACT = 1'b1;
`else
    localparam bit EXACT = 1'b0;
`endif

    amoa_operand_feeder #(.W(8), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5),
        .x6(x6), .x7(x7), .vec_valid(vec_valid), .stall(stall), .exact_sum(exact_sum),
        .vec_cnt(vec_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_vec(input string tag, input logic [7:0] e [8], input int s);
        logic [7:0] xs [8];
        xs = '{x0, x1, x2, x3, x4, x5, x6, x7};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_x%0d", tag, i), {24'd0, xs[i]}, {24'd0, e[i]});
        end
        chk({tag, "_sum"}, {21'd0, exact_sum}, EXACT ? s : 0);
    endtask

    initial begin
        logic [7:0] ev [8];
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'd0; stall = 1'b0;
        step(); step();
        chk("rst_valid", {31'd0, vec_valid}, 32'd0);
        chk("rst_x0", {24'd0, x0}, 32'd0);
        chk("rst_sum", {21'd0, exact_sum}, 32'd0);
        chk("rst_cnt", {16'd0, vec_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        // Basic vector
        ev = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1};
        for (int i = 0; i < 8; i++) send(ev[i]);
        chk("basic_valid", {31'd0, vec_valid}, 32'd1);
        chk_vec("basic", ev, 20);
        step();
        chk("basic_drop", {31'd0, vec_valid}, 32'd0);
        chk("basic_cnt", {16'd0, vec_cnt}, 32'd1);

        // Backpressure fill with DEPTH=2
        stall = 1'b1;
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
        for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
        chk("bp_head0", {24'd0, x0}, 32'h20);
        chk("bp_cnt1", {16'd0, vec_cnt}, 32'd1);
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h40 + 8'(i);
            @(negedge clk);
            chk($sformatf("bp_w%0d_ready", i), {31'd0, in_ready}, 32'd1);
            step();
        end
        in_valid = 1'b1;
        in_data  = 8'h47;
        @(negedge clk);
        chk("bp_w7_blocked", {31'd0, in_ready}, 32'd0);
        step();
        chk("bp_w7_still_blocked", {31'd0, in_ready}, 32'd0);
        chk("bp_head_hold", {24'd0, x0}, 32'h20);
        stall = 1'b0;
        #1;
        chk("bp_w7_ready_on_pop", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        stall    = 1'b1;
        chk("bp_head1", {24'd0, x0}, 32'h30);
        chk("bp_cnt2", {16'd0, vec_cnt}, 32'd2);
        step();
        chk("bp_head1_stable", {24'd0, x0}, 32'h30);
        chk("bp_cnt_stable", {16'd0, vec_cnt}, 32'd2);
        stall = 1'b0;
        step();
        chk("bp_cnt3", {16'd0, vec_cnt}, 32'd3);
        for (int i = 0; i < 8; i++) ev[i] = 8'h40 + 8'(i);
        chk_vec("bp_v2", ev, 540);
        step();
        chk("bp_empty", {31'd0, vec_valid}, 32'd0);
        chk("bp_cnt4", {16'd0, vec_cnt}, 32'd4);

        // Max values
        stall = 1'b1;
        for (int i = 0; i < 8; i++) send(8'd255);
        for (int i = 0; i < 8; i++) ev[i] = 8'd255;
        chk_vec("max", ev, 2040);
        stall = 1'b0;
        step();
        chk("max_cnt5", {16'd0, vec_cnt}, 32'd5);

        // Flush mid-vector
        for (int i = 0; i < 5; i++) send(8'h99);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        flush    = 1'b1;
        #1;
        chk("flush_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        stall    = 1'b1;
        for (int i = 0; i < 8; i++) send(8'd10 + 8'(i));
        for (int i = 0; i < 8; i++) ev[i] = 8'd10 + 8'(i);
        chk("flush_valid", {31'd0, vec_valid}, 32'd1);
        chk_vec("flush", ev, 108);
        stall = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_drop", {31'd0, vec_valid}, 32'd0);
        chk("flush_no_pop", {16'd0, vec_cnt}, 32'd5);

        // Asynchronous reset while stalled with two vectors buffered
        stall = 1'b1;
        for (int i = 0; i < 8; i++) send(8'h50 + 8'(i));
        for (int i = 0; i < 8; i++) send(8'h60 + 8'(i));
        chk("ar_head", {24'd0, x0}, 32'h50);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", {31'd0, vec_valid}, 32'd0);
        chk("ar_x0", {24'd0, x0}, 32'd0);
        chk("ar_x7", {24'd0, x7}, 32'd0);
        chk("ar_sum", {21'd0, exact_sum}, 32'd0);
        step();
        #2;
        rst = 1'b0;
        step();
        chk("ar_cnt", {16'd0, vec_cnt}, 32'd0);
        chk("ar_ready", {31'd0, in_ready}, 32'd1);

        // Counter wrap
        for (int i = 0; i < 8; i++) send(8'h70 + 8'(i));
        force dut.vec_cnt_q = 16'hFFFF;
        #1;
        release dut.vec_cnt_q;
        #1;
        chk("wrap_pre", {16'd0, vec_cnt}, 32'hFFFF);
        stall = 1'b0;
        step();
        chk("wrap_zero", {16'd0, vec_cnt}, 32'd0);
        chk("wrap_empty", {31'd0, vec_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/amoa_operand_feeder.md
# amoa_operand_feeder

Producer-side front end for the 8-operand approximate adder family (`amoa_8x8*`). It accepts a serial stream of 8-bit operand words, assembles them into 8-wide vectors, buffers them in a small FIFO, and drives `x0..x7` into the adder. The adder's `stall` is honoured by holding the presented vector stable. An optional exact-sum sideband lets downstream error monitors compare the approximate `summ` against the true sum.

## Interface
- `W`, 8, operand width in bits.
- `DEPTH`, 2, vector FIFO depth; must be a power of 2, at least 2.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `flush`  input  1  synchronous clear; drops the partial vector and all FIFO contents.
- `in_data`  input  W  operand word.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  feeder can accept `in_data` this cycle.
- `x0`..`x7`  output  W each  FIFO head vector; `x0` is the first word received.
- `vec_valid`  output  1  `x0..x7` hold a valid vector.
- `stall`  input  1  the adder did not consume the vector this cycle.
- `exact_sum`  output  W+3  exact sum of the head vector.
- `vec_cnt`  output  16  count of vectors consumed; wraps modulo 2^16.

## Operation
- **Word acceptance:** a word is accepted when `in_valid && in_ready`. It is written to assembly slot `idx`, where `idx` is a 3-bit counter reset to 0.
- **Push:** accepting the word at `idx==7` pushes the assembled vector into the FIFO and wraps `idx` to 0.
- **Pop:** occurs when `vec_valid && !stall`. `vec_cnt` increments on each pop.
- **`in_ready` rule:** `in_ready = (idx!=7) || !full || pop`.
  - Words 0..6 are always accepted, even when the FIFO is full.
  - Only the completing word waits.
  - `stall` therefore reaches `in_ready` through a combinational path. This path is intended.
- **Simultaneous push and pop:**
  - When full, the occupancy is unchanged and the new vector enters the tail.
  - When the FIFO holds exactly 1 vector, the head advances to the pushed vector one cycle later.
- **Output stability:** `vec_valid = !empty`. `x0..x7` and `exact_sum` change only after a pop, or after a push into an empty FIFO.
- **Exact sum:** `exact_sum` is the unsigned sum of the 8 operands at full W+3 width (no overflow possible). It is computed as each word is accepted and stored with the vector.
- **Flush:**
  - `idx` returns to 0 and the FIFO is emptied.
  - `vec_cnt` is kept.
  - `in_ready` is forced to 0 during the `flush` cycle, and any pop in that cycle is ignored.
  - `flush` overrides push and pop in the same cycle.
- **Reset values (all zero):**
  - `x0..x7`=0, `exact_sum`=0, `vec_cnt`=0.
  - `vec_valid`=0.
  - `idx`=0.
  - `in_ready`=1 once `rst` deasserts.
  - A reset mid-vector discards the partial vector.

## Timing
- **Latency:** if the completing word is accepted in cycle t and the FIFO is empty, `vec_valid`=1 with `x0..x7` valid in cycle t+1.
- **Throughput:** one word per cycle. At most one vector per 8 cycles enters the FIFO; at most one vector per cycle leaves it.
- **Stall:**
  - While `stall`=1, the head and all outputs are bit-stable.
  - `stall` is ignored when `vec_valid`=0: no pop occurs and `vec_cnt` does not change.
- **FIFO pointers:** log2(DEPTH)+1 bits, wrapping naturally. `full` and `empty` are derived from the pointer MSB comparison.

## Configuration
- **`AMOA_FEED_EXACT_EN` defined:** the exact-sum accumulator and per-entry storage are built, and `exact_sum` behaves as described above.
- **`AMOA_FEED_EXACT_EN` undefined:** no accumulator or storage exists, and `exact_sum` is tied to 0. All other behaviour is identical.

## Test plan
- **Basic vector:** after reset, stream 1,2,3,4,4,3,2,1 with `stall`=0.
  - `vec_valid` rises the cycle after the 8th word.
  - `x0..x7` = 1,2,3,4,4,3,2,1 and `exact_sum`=20.
  - `vec_valid` drops the next cycle and `vec_cnt`=1.
- **Backpressure fill (DEPTH=2):** hold `stall`=1 and stream 3 vectors.
  - Head stays at vector 0.
  - Words 0..6 of vector 2 are accepted; `in_ready`=0 at word 7.
  - Dropping `stall` for one cycle lets word 7 enter in that same cycle, and occupancy remains 2.
- **Max values:** eight 255 words → `exact_sum`=2040 with no truncation.
- **Flush mid-vector:** accept 5 words, pulse `flush`, then stream 10..17.
  - The first vector presented is 10..17, `exact_sum`=108.
  - Nothing from the partial vector appears.
- **Async reset during stall:** with 2 vectors buffered and `stall`=1, assert `rst` mid-cycle.
  - Outputs are 0 and `vec_valid`=0 immediately, without waiting for a clock edge.
  - `vec_cnt`=0 after release.
- **Counter wrap and macro build:** force 65536 pops → `vec_cnt` returns to 0. Rerun the basic vector scenario without `AMOA_FEED_EXACT_EN` → `exact_sum` stays 0, all other outputs unchanged.
